shift_add_mult16: RTL and testbench



---
 rtl/shift_add_mult16.sv | 122 ++++++++++++
 tb/tb_shift_add_mult16.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult16.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult16
//  Purpose  : Sequential unsigned 16x16 shift-and-add multiplier that drives
//             a shared external 16-bit adder; 32-bit product in 16 iterations.
//  Revision : 1.0  initial release
// ============================================================================
module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_sum,
    input  logic                 add_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_CNT = 5'(WIDTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_m;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_q;
    logic [4:0]           r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 w_last;

    assign w_last  = (r_cnt == c_LAST_CNT);
    assign product = r_product;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Adder operands are forced to zero outside CALC so the shared adder stays quiet.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_CALC;
                end
            end
            S_CALC: begin
                add_a = r_acc;
                add_b = r_q[0] ? r_m : '0;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // {cout, sum, q} is shifted right as one 33-bit word so no carry is lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m   <= in_a;
                        r_q   <= in_b;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= {add_cout, add_sum[WIDTH-1:1]};
                    r_q   <= {add_sum[0], r_q[WIDTH-1:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_product <= {add_cout, add_sum, r_q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult16
//  Purpose  : Directed + random self-checking bench for shift_add_mult16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mult16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] product;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [15:0] last_or_b;

    // Model of the attached 16-bit adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'b0, add_cin};

    shift_add_mult16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation; bp > 0 holds out_ready low for bp cycles in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag, input int bp);
        int          wt;
        int          lat;
        logic        cin_seen;
        wt = 0;
        while (!in_ready && wt < 40) begin
            tick();
            wt++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat       = 0;
        last_or_b = '0;
        cin_seen  = 1'b0;
        while (!out_valid && lat < 40) begin
            last_or_b = last_or_b | add_b;
            cin_seen  = cin_seen | add_cin;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd16);
        check({tag, "_product"}, product, exp);
        check({tag, "_cin"}, 32'(cin_seen), 32'd0);
        for (int i = 0; i < bp; i++) begin
            in_valid = i[0];
            in_a     = ~a;
            in_b     = ~b;
            tick();
            check({tag, "_bp_hold"}, {out_valid, in_ready, product[29:0]},
                  {1'b1, 1'b0, exp[29:0]});
            check({tag, "_bp_prod"}, product, exp);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check({tag, "_handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          prev_acc;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product",   product,        32'd0);
        check("rst_adder",     {add_a, add_b}, 32'd0);
        check("rst_cin",       32'(add_cin),   32'd0);

        // Directed vectors
        run_op(16'h0003, 16'h0005, 32'h0000_000F, "basic", 0);
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "max", 0);
        run_op(16'h8000, 16'h0002, 32'h0001_0000, "carry", 0);
        run_op(16'h0000, 16'hABCD, 32'h0000_0000, "zero", 0);
        check("zero_add_b", {16'd0, last_or_b}, 32'd0);
        run_op(16'h1234, 16'h0001, 32'h0000_1234, "ident", 0);

        // Backpressure, then a follow-up operation
        out_ready = 1'b0;
        run_op(16'h0102, 16'h0304, 32'h0003_0A08, "bp", 5);
        run_op(16'h00FF, 16'h00FF, 32'h0000_FE01, "after_bp", 0);

        // Reset in the 7th CALC cycle discards the operation
        in_a     = 16'h5555;
        in_b     = 16'h3333;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_product",   product,        32'd0);
        check("midrst_adder",     {add_a, add_b}, 32'd0);
        run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, "post_rst", 0);

        // Back-to-back random with out_ready held high
        prev_acc = 0;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 32'(ra) * 32'(rb), "rand", 0);
            if (i > 0) check("rand_interval", 32'(acc_cyc - prev_acc), 32'd18);
            prev_acc = acc_cyc;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
